// File: rtl/counter_pad_pkg.sv
// Shared types and defaults for the counter pad host: FSM states, parameter
// defaults, timer width and the levels the pads rest at when released.
package counter_pad_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_SETUP   = 3'd1,
        WR_STROBE  = 3'd2,
        WR_RELEASE = 3'd3,
        RD_ENABLE  = 3'd4,
        TURN       = 3'd5
    } state_t;

    localparam int DEF_WIDTH   = 41;
    localparam int DEF_SETTLE  = 2;
    localparam int DEF_WR_HOLD = 2;

    localparam int TMR_W = 8;

    localparam logic PAD_OEB_IDLE = 1'b1;
    localparam logic PAD_WEB_IDLE = 1'b1;
    localparam logic PAD_OE_IDLE  = 1'b0;

endpackage

// File: rtl/counter_pad_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module counter_pad_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/counter_pad_host.sv
// Host-side sequencer for a counter chip on a shared bidirectional bus.
// Build macro COUNTER_PAD_HOST_DELTA_EN adds rsp_delta (sample-to-sample difference).
module counter_pad_host
    import counter_pad_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int WR_HOLD = DEF_WR_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
`ifdef COUNTER_PAD_HOST_DELTA_EN
    output logic [WIDTH-1:0] rsp_delta,
`endif
    output logic             pad_oeb,
    output logic             pad_web,
    output logic             pad_oe,
    output logic [WIDTH-1:0] pad_out,
    input  logic [WIDTH-1:0] pad_in
);

    state_t             state;
    state_t             state_nxt;
    logic               wr_q;
    logic [WIDTH-1:0]   data_q;
    logic               accept;
    logic               sample_en;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_write ? WR_SETUP : RD_ENABLE;
                end
            end
            WR_SETUP:   state_nxt = WR_STROBE;
            WR_STROBE:  if (tmr_done) state_nxt = WR_RELEASE;
            WR_RELEASE: state_nxt = TURN;
            RD_ENABLE:  if (tmr_done) state_nxt = TURN;
            TURN:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Timer is loaded with (cycles - 1) on the edge that enters a timed state.
    always_comb begin
        req_ready = 1'b0;
        accept    = 1'b0;
        pad_oeb   = PAD_OEB_IDLE;
        pad_web   = PAD_WEB_IDLE;
        pad_oe    = PAD_OE_IDLE;
        pad_out   = '0;
        rsp_valid = 1'b0;
        sample_en = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid && !req_write) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETTLE - 1);
                end
            end
            WR_SETUP: begin
                pad_oe   = 1'b1;
                pad_out  = data_q;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(WR_HOLD - 1);
            end
            WR_STROBE: begin
                pad_oe  = 1'b1;
                pad_out = data_q;
                pad_web = 1'b0;
            end
            WR_RELEASE: begin
                pad_oe  = 1'b1;
                pad_out = data_q;
            end
            RD_ENABLE: begin
                pad_oeb   = 1'b0;
                sample_en = tmr_done;
            end
            TURN: begin
                rsp_valid = !wr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            wr_q   <= req_write;
            data_q <= req_data;
        end
    end

`ifdef COUNTER_PAD_HOST_DELTA_EN
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_delta <= '0;
            prev_q    <= '0;
        end else if (sample_en) begin
            rsp_data  <= pad_in;
            rsp_delta <= pad_in - prev_q;
            prev_q    <= pad_in;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
        end else if (sample_en) begin
            rsp_data <= pad_in;
        end
    end
`endif

    counter_pad_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

endmodule

// File: tb/tb_counter_pad_host.sv
// Directed bench for counter_pad_host (WIDTH=41, SETTLE=2, WR_HOLD=2); the delta
// checks are compiled in when COUNTER_PAD_HOST_DELTA_EN is defined.
module tb_counter_pad_host;

    localparam int W = 41;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [W-1:0] req_data;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic [W-1:0] rsp_delta;
    logic         pad_oeb;
    logic         pad_web;
    logic         pad_oe;
    logic [W-1:0] pad_out;
    logic [W-1:0] pad_in;

    int total = 0;
    int bad   = 0;
    int overlap_err = 0;
    logic prev_oe  = 1'b0;
    logic prev_oeb = 1'b1;

    counter_pad_host #(
        .WIDTH(41),
        .SETTLE(2),
        .WR_HOLD(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
`ifdef COUNTER_PAD_HOST_DELTA_EN
        .rsp_delta (rsp_delta),
`endif
        .pad_oeb   (pad_oeb),
        .pad_web   (pad_web),
        .pad_oe    (pad_oe),
        .pad_out   (pad_out),
        .pad_in    (pad_in)
    );

`ifndef COUNTER_PAD_HOST_DELTA_EN
    assign rsp_delta = '0;
`endif

    always #5 clk = ~clk;

    // Bus-contention watch: never both drivers on, never a direct hand-over.
    always @(negedge clk) begin
        if (pad_oe && !pad_oeb) overlap_err <= overlap_err + 1;
        if (prev_oe && !pad_oeb) overlap_err <= overlap_err + 1;
        if (!prev_oeb && pad_oe) overlap_err <= overlap_err + 1;
        prev_oe  <= pad_oe;
        prev_oeb <= pad_oeb;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_read(input logic [W-1:0] val, output int seen,
                            output logic [W-1:0] dat, output logic [W-1:0] dlt);
        seen = -1;
        dat  = '0;
        dlt  = '0;
        pad_in    = val;
        req_write = 1'b0;
        req_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) req_valid = 1'b0;
            if (rsp_valid && seen < 0) begin
                seen = c;
                dat  = rsp_data;
                dlt  = rsp_delta;
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_data  = 41'h0_DEAD_BEEF;
        pad_in    = 41'h0_0F0F_0F0F;
        tick();
        tick();
        total++;
        if ({pad_oeb, pad_web, pad_oe, req_ready, rsp_valid} !== 5'b11010) begin
            bad++;
            $display("FAIL reset_ctrl got oeb,web,oe,ready,valid=%b want 11010",
                     {pad_oeb, pad_web, pad_oe, req_ready, rsp_valid});
        end
        total++;
        if (pad_out !== '0 || rsp_data !== '0) begin
            bad++;
            $display("FAIL reset_data got pad_out=%h rsp_data=%h want 0", pad_out, rsp_data);
        end
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write;
        logic [W-1:0] d;
        logic [4:0]   exp_ctl;
        logic [W-1:0] exp_out;
        d = 41'h0_1234_5678;
        req_write = 1'b1;
        req_data  = d;
        req_valid = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_ready0 got %b want 1", req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                req_valid = 1'b0;
                req_data  = 41'h0_FFFF_0000;
            end
            // oe, web, oeb, rsp_valid, req_ready
            exp_ctl = {(c >= 1 && c <= 4), !(c == 2 || c == 3), 1'b1, 1'b0, (c == 6)};
            exp_out = (c >= 1 && c <= 4) ? d : '0;
            total++;
            if ({pad_oe, pad_web, pad_oeb, rsp_valid, req_ready} !== exp_ctl) begin
                bad++;
                $display("FAIL wr_ctl c=%0d got oe,web,oeb,valid,ready=%b want %b",
                         c, {pad_oe, pad_web, pad_oeb, rsp_valid, req_ready}, exp_ctl);
            end
            total++;
            if (pad_out !== exp_out) begin
                bad++;
                $display("FAIL wr_out c=%0d got %h want %h", c, pad_out, exp_out);
            end
        end
    endtask

    task automatic test_read;
        logic [4:0] exp_ctl;
        req_write = 1'b0;
        pad_in    = 41'h1FF_FFFF_FFFF;
        req_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) req_valid = 1'b0;
            exp_ctl = {1'b0, 1'b1, !(c == 1 || c == 2), (c == 3), (c >= 4)};
            total++;
            if ({pad_oe, pad_web, pad_oeb, rsp_valid, req_ready} !== exp_ctl) begin
                bad++;
                $display("FAIL rd_ctl c=%0d got oe,web,oeb,valid,ready=%b want %b",
                         c, {pad_oe, pad_web, pad_oeb, rsp_valid, req_ready}, exp_ctl);
            end
            if (c == 3) begin
                total++;
                if (rsp_data !== 41'h1FF_FFFF_FFFF) begin
                    bad++;
                    $display("FAIL rd_data got %h want 1ffffffffff", rsp_data);
                end
                pad_in = 41'h0_0000_5555;
            end
        end
        total++;
        if (rsp_data !== 41'h1FF_FFFF_FFFF) begin
            bad++;
            $display("FAIL rd_hold got %h want 1ffffffffff", rsp_data);
        end
    endtask

    task automatic test_ignore;
        req_write = 1'b0;
        pad_in    = 41'h0_0000_0123;
        req_valid = 1'b1;
        tick();
        req_write = 1'b1;
        req_data  = 41'h0_0000_0BAD;
        tick();
        tick();
        req_valid = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            tick();
            total++;
            if ({pad_oe, pad_web, pad_oeb, req_ready} !== 4'b0111) begin
                bad++;
                $display("FAIL ignore c=%0d got oe,web,oeb,ready=%b want 0111",
                         c, {pad_oe, pad_web, pad_oeb, req_ready});
            end
        end
    endtask

    task automatic test_back_to_back;
        int last_oe;
        int first_oeb;
        int seen;
        logic [W-1:0] got;
        last_oe   = -1;
        first_oeb = -1;
        seen      = -1;
        got       = '0;
        req_write = 1'b1;
        req_data  = 41'h0_00AA_55AA;
        pad_in    = 41'h0_0000_4242;
        req_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) req_valid = 1'b0;
            if (c == 6) begin
                req_write = 1'b0;
                req_valid = 1'b1;
            end
            if (c == 7) req_valid = 1'b0;
            if (pad_oe) last_oe = c;
            if (!pad_oeb && first_oeb < 0) first_oeb = c;
            if (rsp_valid && seen < 0) begin
                seen = c;
                got  = rsp_data;
            end
        end
        total++;
        if (last_oe != 4 || first_oeb != 7) begin
            bad++;
            $display("FAIL b2b_turn got last_oe=%0d first_oeb=%0d want 4 and 7", last_oe, first_oeb);
        end
        total++;
        if (seen != 9 || got !== 41'h0_0000_4242) begin
            bad++;
            $display("FAIL b2b_read got cycle=%0d data=%h want 9 and 4242", seen, got);
        end
        total++;
        if (overlap_err != 0) begin
            bad++;
            $display("FAIL b2b_overlap got %0d violations want 0", overlap_err);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        logic [W-1:0] dat;
        logic [W-1:0] dlt;
        req_write = 1'b1;
        req_data  = 41'h0_0777_7777;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        total++;
        if (pad_web !== 1'b0 || pad_oe !== 1'b1) begin
            bad++;
            $display("FAIL mid_strobe got web=%b oe=%b want 0 1", pad_web, pad_oe);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({pad_web, pad_oe, pad_oeb, req_ready, rsp_valid} !== 5'b10110 || pad_out !== '0) begin
            bad++;
            $display("FAIL mid_reset got web,oe,oeb,ready,valid=%b pad_out=%h want 10110 0",
                     {pad_web, pad_oe, pad_oeb, req_ready, rsp_valid}, pad_out);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0 || pad_oe !== 1'b0) begin
            bad++;
            $display("FAIL mid_hold got valid=%b oe=%b want 0 0", rsp_valid, pad_oe);
        end
        rst = 1'b0;
        run_read(41'h0_0ABC_DEF0, seen, dat, dlt);
        total++;
        if (seen != 3 || dat !== 41'h0_0ABC_DEF0) begin
            bad++;
            $display("FAIL mid_read got cycle=%0d data=%h want 3 abcdef0", seen, dat);
        end
    endtask

`ifdef COUNTER_PAD_HOST_DELTA_EN
    task automatic test_delta;
        int seen;
        logic [W-1:0] dat;
        logic [W-1:0] dlt;
        apply_reset();
        run_read(41'd100, seen, dat, dlt);
        total++;
        if (seen != 3 || dlt !== 41'd100) begin
            bad++;
            $display("FAIL delta_100 got cycle=%0d delta=%0d want 3 100", seen, dlt);
        end
        run_read(41'd250, seen, dat, dlt);
        total++;
        if (dlt !== 41'd150) begin
            bad++;
            $display("FAIL delta_150 got %0d want 150", dlt);
        end
        apply_reset();
        run_read(41'h1FF_FFFF_FFFF, seen, dat, dlt);
        total++;
        if (dlt !== 41'h1FF_FFFF_FFFF) begin
            bad++;
            $display("FAIL delta_max got %h want 1ffffffffff", dlt);
        end
        run_read(41'd5, seen, dat, dlt);
        total++;
        if (dlt !== 41'd6) begin
            bad++;
            $display("FAIL delta_wrap got %0d want 6", dlt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_data  = '0;
        pad_in    = '0;
        test_reset();
        test_write();
        test_read();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef COUNTER_PAD_HOST_DELTA_EN
        test_delta();
`endif
        tick();
        total++;
        if (overlap_err != 0) begin
            bad++;
            $display("FAIL overlap_total got %0d violations want 0", overlap_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_pad_host.md
COUNTER_PAD_HOST -- requirements
Module: counter_pad_host

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
 - WIDTH, 41, counter/pad data width.
 - SETTLE, 2, read cycles with pad_oeb low before sampling (>=1).
 - WR_HOLD, 2, write-strobe cycles with pad_web low (>=1).
REQ-002 SHALL have ports, one per line: name direction width meaning. There SHALL be one clock, and reset SHALL be asynchronous and active-high.
 - clk in 1 sole clock, rising edge.
 - rst in 1 asynchronous active-high reset.
 - req_valid in 1 host request strobe.
 - req_ready out 1 block can accept a request.
 - req_write in 1 1=write count_set, 0=read count.
 - req_data in WIDTH write value.
 - rsp_valid out 1 one-cycle read-data pulse.
 - rsp_data out WIDTH sampled count.
 - rsp_delta out WIDTH delta output, present only with the macro of REQ-016.
 - pad_oeb out 1 chip output enable, active low.
 - pad_web out 1 chip count load strobe, active low.
 - pad_oe out 1 host drive enable for pad_out onto shared bus.
 - pad_out out WIDTH value driven while pad_oe=1.
 - pad_in in WIDTH shared bus as seen by host.

Function
REQ-003 SHALL implement FSM states IDLE, WR_SETUP, WR_STROBE, WR_RELEASE, RD_ENABLE, TURN; req_ready=1 only in IDLE; a request is accepted on req_valid&req_ready (cycle N).
REQ-004 Write SHALL be sequenced as follows:
 - WR_SETUP at N+1: pad_oe=1, pad_out=req_data (latched at acceptance).
 - WR_STROBE from N+2 to N+1+WR_HOLD: pad_web=0.
 - WR_RELEASE at N+2+WR_HOLD: pad_web=1, pad_oe=1.
 - TURN at N+3+WR_HOLD: pad_oe=0.
 - IDLE at N+4+WR_HOLD.
REQ-005 A write SHALL produce no rsp_valid.
REQ-006 Read SHALL be sequenced as follows:
 - RD_ENABLE from N+1 to N+SETTLE: pad_oeb=0, pad_oe=0.
 - On the last RD_ENABLE cycle, pad_in SHALL be registered into rsp_data.
 - TURN at N+SETTLE+1: pad_oeb=1, rsp_valid=1 for exactly one cycle.
 - IDLE at N+SETTLE+2.
REQ-007 pad_oe=1 and pad_oeb=0 SHALL never coexist, and at least one cycle with both released SHALL separate host drive from chip drive.
REQ-008 pad_web SHALL be 0 only while pad_oe=1 and pad_out is stable.
REQ-009 rsp_data SHALL hold its value until the next read sample.
REQ-010 req_valid outside IDLE SHALL be ignored, not queued.
REQ-011 A single internal down-counter SHALL time SETTLE and WR_HOLD; it SHALL be loaded on state entry and must not wrap.

Reset
REQ-012 While rst=1, outputs SHALL be asynchronously forced to: pad_oeb=1, pad_web=1, pad_oe=0, pad_out=0, rsp_valid=0, rsp_data=0, rsp_delta=0, state=IDLE, and req_ready=1.
REQ-013 Reset asserted mid-transaction SHALL release all pads in the same cycle, drop the transaction and emit no rsp_valid.
REQ-014 After rst deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-015 Macro COUNTER_PAD_HOST_DELTA_EN SHALL control rsp_delta.
REQ-016 With COUNTER_PAD_HOST_DELTA_EN defined:
 - rsp_delta SHALL be present and SHALL be valid with rsp_valid.
 - rsp_delta = new sample minus previous sample, mod 2^WIDTH.
 - The previous sample SHALL be 0 after reset.
REQ-017 Without COUNTER_PAD_HOST_DELTA_EN, the port, the previous-sample register and the subtractor SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-018 Package counter_pad_pkg SHALL hold the FSM state enum, WIDTH/SETTLE/WR_HOLD defaults, and the pad idle-level constants.
REQ-019 There SHALL be one sub-module, counter_pad_timer: a loadable down-counter with a done flag, used for SETTLE and WR_HOLD.

Verification (WIDTH=41, SETTLE=2, WR_HOLD=2)
REQ-020 Reset: rst=1 with any inputs -> pad_oeb=1, pad_web=1, pad_oe=0, req_ready=1, rsp_valid=0.
REQ-021 Write 41'h0_1234_5678 accepted at cycle 0 -> pad_oe=1 at cycles 1-4, pad_web=0 at cycles 2-3 with pad_out=41'h0_1234_5678, pad_oe=0 at cycle 5, req_ready=1 at cycle 6.
REQ-022 Read accepted at cycle 0 with pad_in=41'h1FF_FFFF_FFFF -> pad_oeb=0 at cycles 1-2, rsp_valid pulse at cycle 3 with rsp_data=41'h1FF_FFFF_FFFF, req_ready=1 at cycle 4.
REQ-023 Back-to-back write then read, with a REQ-007 assertion running -> no overlap, at least one released cycle between pad_oe falling and pad_oeb falling.
REQ-024 rst pulsed during WR_STROBE -> pad_web=1 and pad_oe=0 immediately, no rsp_valid, and a fresh read afterwards completes normally.
REQ-025 COUNTER_PAD_HOST_DELTA_EN checks:
 - Reads returning 100 then 250 -> rsp_delta=100 then 150.
 - Reads returning 41'h1FF_FFFF_FFFF then 5 -> rsp_delta=6.
